// File: rtl/bit_gather.sv
// bit_gather
// Serial-to-parallel receiver. Framed single bits (LSB first, in_start on
// bit 0) are collected into a WIDTH-bit word. The word is offered on a
// valid/ready output port. Framing errors are counted in a saturating
// counter.
//
// Ports
//   clk       : clock, rising-edge active
//   rst       : synchronous active-high reset
//   in_valid  : in_bit / in_start are valid this cycle
//   in_start  : marks bit 0 of a word
//   in_bit    : serial data bit
//   in_ready  : receiver accepts the input this cycle (combinational,
//               independent of in_valid)
//   out_word  : assembled word, bit i = i-th accepted bit
//   out_valid : out_word holds an undelivered word
//   out_ready : consumer takes out_word this cycle
//   err_cnt   : saturating framing-error count
module bit_gather #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_word,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) begin
            return v;
        end else begin
            return v + ERR_W'(1);
        end
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic             out_valid_q, out_valid_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             accept_s;
    logic             deliver_s;
    logic             complete_s;
    logic [WIDTH-1:0] shift_ins_s;
    logic [WIDTH-1:0] start_word_s;

    // Only a completing bit can stall, and only while the output register
    // is full and not draining. Restart bits are always accepted.
    assign in_ready  = !((state_q == ST_COLLECT) && (cnt_q == CNT_LAST) &&
                         !in_start && out_valid_q && !out_ready);
    assign accept_s  = in_valid && in_ready;
    assign deliver_s = out_valid_q && out_ready;

    assign start_word_s = {{(WIDTH-1){1'b0}}, in_bit};

    // Shift register with the incoming bit written at index cnt_q.
    always_comb begin
        shift_ins_s = shift_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                shift_ins_s[i] = in_bit;
            end else begin
                shift_ins_s[i] = shift_q[i];
            end
        end
    end

    // Next-state logic for the framing FSM, bit counter and error counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        err_cnt_d  = err_cnt_q;
        complete_s = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_start) begin
                        state_d = ST_COLLECT;
                        shift_d = start_word_s;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        // Bit without a frame start: dropped.
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
                ST_COLLECT: begin
                    if (in_start) begin
                        // Restart: discard the partial word, keep collecting.
                        err_cnt_d = sat_inc(err_cnt_q);
                        shift_d   = start_word_s;
                        cnt_d     = CNT_W'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        shift_d    = shift_ins_s;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                        complete_s = 1'b1;
                    end else begin
                        shift_d = shift_ins_s;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output register: a completion wins over a same-cycle delivery.
    always_comb begin
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        if (complete_s) begin
            out_word_d  = shift_ins_s;
            out_valid_d = 1'b1;
        end else if (deliver_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/bit_gather.md
# bit_gather

Serial-to-parallel receiver that collects single framed bits into a WIDTH-bit word and presents it through a valid/ready output port. It performs the reverse of splitting a bus such as `[2:0]` into individual bit nets feeding separate instances: it gathers those bits back into a bus. It sits between a bit-serial producer and any by-name-instantiated consumer of the packed word.

## Interface

- `WIDTH`, default 3: bits per word; legal range 2..16.
- `ERR_W`, default 8: width of the saturating error counter.
- `clk`  input  1  : single clock; all state updates on the rising edge.
- `rst`  input  1  : synchronous, active-high reset.
- `in_valid`  input  1  : `in_bit`/`in_start` are valid this cycle.
- `in_start`  input  1  : marks the first bit (bit 0) of a word.
- `in_bit`  input  1  : serial data bit, LSB first.
- `in_ready`  output  1  : receiver accepts the input this cycle.
- `out_word`  output  WIDTH  : assembled word, bit i = i-th accepted bit.
- `out_valid`  output  1  : `out_word` holds an undelivered word.
- `out_ready`  input  1  : consumer takes `out_word` this cycle.
- `err_cnt`  output  ERR_W  : saturating count of framing errors.

## Operation

- An input is accepted when `in_valid && in_ready`. An output is delivered when `out_valid && out_ready`.
- State machine:
  - IDLE to COLLECT: an accepted bit with `in_start=1` is stored as bit 0, and `cnt` becomes 1.
  - IDLE, accepted bit with `in_start=0`: the bit is dropped, `err_cnt` is incremented, and the state stays IDLE.
  - COLLECT, accepted bit with `in_start=0`: the bit is stored at index `cnt`.
    - If `cnt==WIDTH-1`, the word is complete: the shift register is copied to `out_word`, `out_valid` is set, and the state returns to IDLE.
    - Otherwise `cnt` increments.
  - COLLECT, accepted bit with `in_start=1`: the partial word is discarded, `err_cnt` is incremented, the bit becomes the new bit 0, `cnt` becomes 1, and the state stays COLLECT.
- `in_ready` is combinational. It equals `!(state==COLLECT && cnt==WIDTH-1 && in_start==0 && out_valid && !out_ready)`.
  - Only a completing bit stalls, and only when the output register is full and not draining.
  - A restart bit (`in_start=1`) is always accepted.
- Output register:
  - A completion and a delivery in the same cycle leave `out_valid=1` and load the new word.
  - A delivery with no completion clears `out_valid`.
  - `out_word` holds its value while `out_valid=1`. After delivery it retains the last value.
- `err_cnt` saturates at 2^ERR_W-1 and never wraps. It clears only on reset.
- Unaccepted cycles (`in_valid=0`, or a stalled bit) change no state.

## Timing

- Reset values:
  - `state` = IDLE, `cnt` = 0, shift register = 0.
  - `out_word` = 0, `out_valid` = 0, `err_cnt` = 0.
  - `in_ready` = 1, because the block comes out of reset in IDLE.
- Latency: if the final bit is accepted in cycle N, `out_valid` is 1 and `out_word` is valid from cycle N+1.
- Throughput: one word per WIDTH cycles with no bubbles when `out_ready` is held at 1. Back-to-back `in_start` immediately after completion is legal.
- Reset asserted mid-word discards the partial word and any undelivered output word. No output is produced.
- `in_ready` must not depend on `in_valid`, so there is no combinational loop with a producer that waits on ready.

## Test plan

- Reset, then with `out_ready=1` stream bits 1,0,1 with `in_start` on the first -> `out_word=3'b101` and `out_valid=1` for exactly one cycle, 1 cycle after the third bit; `err_cnt=0`.
- Hold `out_ready=0`. Send word 3'b011, then word 3'b110 -> first word is held; `in_ready=0` only on the third bit of the second word. Then raise `out_ready` -> 3'b011 is delivered, then 3'b110; no loss, no duplication.
- Send `in_start`, bit 1, then `in_start` again with bits 0,0,1 -> the partial word is discarded, `err_cnt=1`, and `out_word=3'b100`.
- Send 300 valid bits with `in_start=0` from IDLE -> no output; `err_cnt` saturates at 255.
- Assert `rst` after 2 bits of a word, then send a full new word 3'b010 -> only 3'b010 is output; `err_cnt=0`.
- Keep `out_ready=1` and send continuous `in_start`-framed words 0..7 -> eight outputs in order, one every 3 cycles; `in_ready` stays 1 throughout.
